// File: rtl/cpu_pkg.sv
// Shared register-file geometry and the ID->EX operand bundle.
package cpu_pkg;

  localparam int REG_WIDTH  = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int REG_DEPTH  = 1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_WIDTH-1:0]  op1;
    logic [REG_WIDTH-1:0]  op2;
    logic [ADDR_WIDTH-1:0] rd;
    logic                  rd_wr;
  } id_to_ex_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy tracking for in-flight writers; reports RAW and WAW hazards
// for the instruction currently presented by decode.
module reg_scoreboard #(
  parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
  parameter int REG_DEPTH  = cpu_pkg::REG_DEPTH
) (
  input  logic                  clk,
  input  logic                  reg_rst_n,
  input  logic [ADDR_WIDTH-1:0] rs1_i,
  input  logic [ADDR_WIDTH-1:0] rs2_i,
  input  logic                  uses_rs1_i,
  input  logic                  uses_rs2_i,
  input  logic [ADDR_WIDTH-1:0] rd_i,
  input  logic                  rd_wr_i,
  input  logic                  bhit1_i,
  input  logic                  bhit2_i,
  input  logic                  wb_en_i,
  input  logic [ADDR_WIDTH-1:0] wb_addr_i,
  input  logic                  issue_i,
  input  logic                  flush_clr_i,
  input  logic [ADDR_WIDTH-1:0] flush_addr_i,
  output logic                  raw_hazard_o,
  output logic                  waw_hazard_o
);
  import cpu_pkg::*;

  logic [REG_DEPTH-1:0] busy_q, busy_d;

  // Clears are applied first so that a same-cycle set on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_en_i)
      busy_d[wb_addr_i] = 1'b0;
    if (flush_clr_i)
      busy_d[flush_addr_i] = 1'b0;
    if (issue_i && rd_wr_i)
      busy_d[rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reg_rst_n) begin
    if (!reg_rst_n)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  assign raw_hazard_o = (uses_rs1_i && busy_q[rs1_i] && !bhit1_i) ||
                        (uses_rs2_i && busy_q[rs2_i] && !bhit2_i);

  assign waw_hazard_o = rd_wr_i && (rd_i != REG_ZERO) && busy_q[rd_i] &&
                        !(wb_en_i && (wb_addr_i == rd_i));

endmodule

// File: rtl/operand_fetch.sv
// Operand read, writeback bypass and registered ID->EX stage in front of the 32x32 register file.
// Same-cycle writeback bypass is built only when OPFETCH_WB_BYPASS_EN is defined.
module operand_fetch #(
  parameter int REG_WIDTH  = cpu_pkg::REG_WIDTH,
  parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
  parameter int REG_DEPTH  = cpu_pkg::REG_DEPTH
) (
  input  logic                  clk,
  input  logic                  reg_rst_n,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [ADDR_WIDTH-1:0] id_rs1,
  input  logic [ADDR_WIDTH-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [ADDR_WIDTH-1:0] id_rd,
  input  logic                  id_rd_wr,
  output logic [ADDR_WIDTH-1:0] rf_read_addr_1,
  output logic [ADDR_WIDTH-1:0] rf_read_addr_2,
  input  logic [REG_WIDTH-1:0]  rf_data_1,
  input  logic [REG_WIDTH-1:0]  rf_data_2,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [REG_WIDTH-1:0]  wb_data,
  input  logic                  flush,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [REG_WIDTH-1:0]  ex_op1,
  output logic [REG_WIDTH-1:0]  ex_op2,
  output logic [ADDR_WIDTH-1:0] ex_rd,
  output logic                  ex_rd_wr
);
  import cpu_pkg::*;

  id_to_ex_t              ex_q, ex_d;
  logic                   ex_valid_q, ex_valid_d;
  logic                   bhit1, bhit2;
  logic                   raw_hazard, waw_hazard;
  logic                   stage_free, issue;
  logic [REG_WIDTH-1:0]   op1_rd, op2_rd, op1_sel, op2_sel;

  assign rf_read_addr_1 = id_rs1;
  assign rf_read_addr_2 = id_rs2;

`ifdef OPFETCH_WB_BYPASS_EN
  assign bhit1  = wb_en && (wb_addr == id_rs1) && (id_rs1 != REG_ZERO);
  assign bhit2  = wb_en && (wb_addr == id_rs2) && (id_rs2 != REG_ZERO);
  assign op1_rd = bhit1 ? wb_data : rf_data_1;
  assign op2_rd = bhit2 ? wb_data : rf_data_2;
`else
  // Without bypass the dependent instruction waits one cycle and reads the file.
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign bhit1  = 1'b0;
  assign bhit2  = 1'b0;
  assign op1_rd = rf_data_1;
  assign op2_rd = rf_data_2;
`endif

  // x0 reads as zero regardless of what the file or the writeback bus carries.
  assign op1_sel = (id_rs1 == REG_ZERO) ? '0 : op1_rd;
  assign op2_sel = (id_rs2 == REG_ZERO) ? '0 : op2_rd;

  assign stage_free = !ex_valid_q || ex_ready;
  assign id_ready   = stage_free && !flush && !raw_hazard && !waw_hazard;
  assign issue      = id_valid && id_ready;

  reg_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .REG_DEPTH  (REG_DEPTH)
  ) u_scoreboard (
    .clk          (clk),
    .reg_rst_n    (reg_rst_n),
    .rs1_i        (id_rs1),
    .rs2_i        (id_rs2),
    .uses_rs1_i   (id_uses_rs1),
    .uses_rs2_i   (id_uses_rs2),
    .rd_i         (id_rd),
    .rd_wr_i      (id_rd_wr),
    .bhit1_i      (bhit1),
    .bhit2_i      (bhit2),
    .wb_en_i      (wb_en),
    .wb_addr_i    (wb_addr),
    .issue_i      (issue),
    .flush_clr_i  (flush && ex_valid_q && ex_q.rd_wr),
    .flush_addr_i (ex_q.rd),
    .raw_hazard_o (raw_hazard),
    .waw_hazard_o (waw_hazard)
  );

  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    if (issue) begin
      ex_d       = '{op1: op1_sel, op2: op2_sel, rd: id_rd, rd_wr: id_rd_wr};
      ex_valid_d = 1'b1;
    end else if (flush || ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reg_rst_n) begin
    if (!reg_rst_n) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_op1   = ex_q.op1;
  assign ex_op2   = ex_q.op2;
  assign ex_rd    = ex_q.rd;
  assign ex_rd_wr = ex_q.rd_wr;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed table, reset-mid-operation sequence,
// then randomized traffic against a scoreboard-level reference model.
module tb_operand_fetch;

`ifdef OPFETCH_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reg_rst_n;
  logic        id_valid, id_ready, id_uses_rs1, id_uses_rs2, id_rd_wr;
  logic [4:0]  id_rs1, id_rs2, id_rd, rf_read_addr_1, rf_read_addr_2, wb_addr, ex_rd;
  logic [31:0] rf_data_1, rf_data_2, wb_data, ex_op1, ex_op2;
  logic        wb_en, flush, ex_valid, ex_ready, ex_rd_wr;

  always #5 clk = ~clk;

  logic [31:0] rf_mem [32];
  assign rf_data_1 = rf_mem[rf_read_addr_1];
  assign rf_data_2 = rf_mem[rf_read_addr_2];

  operand_fetch dut (
    .clk(clk), .reg_rst_n(reg_rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_rd_wr(id_rd_wr),
    .rf_read_addr_1(rf_read_addr_1), .rf_read_addr_2(rf_read_addr_2),
    .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_rd(ex_rd), .ex_rd_wr(ex_rd_wr)
  );

  typedef struct {
    logic        id_valid;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, rd_wr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush, ex_ready;
    logic        chk_ready, exp_ready;
    logic        chk_op;
    logic [31:0] exp_op1, exp_op2;
    logic [4:0]  exp_rd;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: which registers have a writer in flight, and the EX stage contents.
  bit          m_busy [32];
  logic        m_v, m_rdwr;
  logic [31:0] m_op1, m_op2;
  logic [4:0]  m_rd;

  vec_t tbl[$];
  vec_t v;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t ins(input bit valid, input logic [4:0] rs1, input bit u1,
                               input logic [4:0] rs2, input bit u2, input logic [4:0] rd,
                               input bit rd_wr, input bit exr, input bit chk, input bit er);
    vec_t r;
    r.id_valid = valid; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2;
    r.rd = rd; r.rd_wr = rd_wr; r.ex_ready = exr;
    r.wb_en = 1'b0; r.wb_addr = '0; r.wb_data = '0; r.flush = 1'b0;
    r.chk_ready = chk; r.exp_ready = er;
    r.chk_op = 1'b0; r.exp_op1 = '0; r.exp_op2 = '0; r.exp_rd = '0;
    return r;
  endfunction

  function automatic vec_t with_wb(input vec_t i, input logic [4:0] a, input logic [31:0] d);
    vec_t r = i;
    r.wb_en = 1'b1; r.wb_addr = a; r.wb_data = d;
    return r;
  endfunction

  function automatic vec_t with_op(input bit en, input vec_t i, input logic [31:0] o1,
                                   input logic [31:0] o2, input logic [4:0] rd);
    vec_t r = i;
    r.chk_op = en; r.exp_op1 = o1; r.exp_op2 = o2; r.exp_rd = rd;
    return r;
  endfunction

  function automatic bit m_bhit(input vec_t x, input logic [4:0] s);
    return BYP && x.wb_en && (x.wb_addr == s) && (s != 5'd0);
  endfunction

  function automatic logic [31:0] m_operand(input vec_t x, input logic [4:0] s);
    if (s == 5'd0) return 32'd0;
    if (m_bhit(x, s)) return x.wb_data;
    return rf_mem[s];
  endfunction

  function automatic bit m_ready(input vec_t x);
    bit raw1, raw2, waw;
    raw1 = x.u1 && m_busy[x.rs1] && !m_bhit(x, x.rs1);
    raw2 = x.u2 && m_busy[x.rs2] && !m_bhit(x, x.rs2);
    waw  = x.rd_wr && (x.rd != 5'd0) && m_busy[x.rd] && !(x.wb_en && x.wb_addr == x.rd);
    return (!m_v || x.ex_ready) && !x.flush && !raw1 && !raw2 && !waw;
  endfunction

  task automatic cyc(input vec_t x);
    bit er, iss;
    logic [31:0] n1, n2;
    id_valid = x.id_valid; id_rs1 = x.rs1; id_rs2 = x.rs2;
    id_uses_rs1 = x.u1; id_uses_rs2 = x.u2; id_rd = x.rd; id_rd_wr = x.rd_wr;
    wb_en = x.wb_en; wb_addr = x.wb_addr; wb_data = x.wb_data;
    flush = x.flush; ex_ready = x.ex_ready;
    #1;
    er = m_ready(x);
    n1 = m_operand(x, x.rs1);
    n2 = m_operand(x, x.rs2);
    check("id_ready", 32'(id_ready), 32'(er));
    if (x.chk_ready) check("id_ready_tbl", 32'(id_ready), 32'(x.exp_ready));
    check("rf_addr", 32'({rf_read_addr_2, rf_read_addr_1}), 32'({x.rs2, x.rs1}));
    check("ex_valid", 32'(ex_valid), 32'(m_v));
    check("ex_op1", ex_op1, m_op1);
    check("ex_op2", ex_op2, m_op2);
    check("ex_rd", 32'({ex_rd, ex_rd_wr}), 32'({m_rd, m_rdwr}));
    @(posedge clk);
    #1;
    iss = x.id_valid && er;
    if (x.wb_en && x.wb_addr != 5'd0) begin
      m_busy[x.wb_addr] = 1'b0;
      rf_mem[x.wb_addr] = x.wb_data;
    end
    if (x.flush && m_v && m_rdwr) m_busy[m_rd] = 1'b0;
    if (iss && x.rd_wr && x.rd != 5'd0) m_busy[x.rd] = 1'b1;
    if (iss) begin
      m_v = 1'b1; m_op1 = n1; m_op2 = n2; m_rd = x.rd; m_rdwr = x.rd_wr;
    end else if (x.flush || x.ex_ready) begin
      m_v = 1'b0;
    end
    @(negedge clk);
    if (x.chk_op) begin
      check("ex_valid_const", 32'(ex_valid), 32'd1);
      check("ex_op1_const", ex_op1, x.exp_op1);
      check("ex_op2_const", ex_op2, x.exp_op2);
      check("ex_rd_const", 32'(ex_rd), 32'(x.exp_rd));
    end
  endtask

  task automatic do_reset();
    reg_rst_n = 1'b0;
    #1;
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_ex_op1", ex_op1, 32'd0);
    check("rst_ex_op2", ex_op2, 32'd0);
    check("rst_ex_rd", 32'({ex_rd, ex_rd_wr}), 32'd0);
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_v = 1'b0; m_op1 = '0; m_op2 = '0; m_rd = '0; m_rdwr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reg_rst_n = 1'b1;
  endtask

  initial begin
    // Directed table: back-to-back dependency, RAW stall, x0, backpressure, flush/WAW.
    tbl.push_back(ins(1, 0, 0, 0, 0, 3, 1, 1, 1, 1));
    tbl.push_back(with_op(BYP, with_wb(ins(1, 3, 1, 0, 0, 4, 0, 1, 1, BYP), 3, 32'hDEADBEEF),
                          32'hDEADBEEF, 32'd0, 5'd4));
    tbl.push_back(with_op(1, ins(1, 3, 1, 0, 0, 4, 0, 1, 1, 1), 32'hDEADBEEF, 32'd0, 5'd4));
    tbl.push_back(ins(1, 0, 0, 0, 0, 7, 1, 1, 1, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(ins(1, 0, 0, 7, 1, 8, 0, 1, 1, 0));
    tbl.push_back(with_op(BYP, with_wb(ins(1, 0, 0, 7, 1, 8, 0, 1, 1, BYP), 7, 32'h7777_0007),
                          32'd0, 32'h7777_0007, 5'd8));
    tbl.push_back(with_op(1, ins(1, 0, 0, 7, 1, 8, 0, 1, 1, 1), 32'd0, 32'h7777_0007, 5'd8));
    tbl.push_back(with_op(1, with_wb(ins(1, 0, 1, 0, 0, 0, 1, 1, 1, 1), 0, 32'h1234),
                          32'd0, 32'd0, 5'd0));
    tbl.push_back(ins(1, 0, 1, 0, 1, 0, 1, 1, 1, 1));
    tbl.push_back(with_op(1, ins(1, 10, 1, 11, 1, 12, 1, 1, 1, 1), 32'hC0DE_000A, 32'hC0DE_000B, 5'd12));
    for (int i = 0; i < 2; i++)
      tbl.push_back(with_op(1, ins(1, 13, 1, 0, 0, 14, 1, 0, 1, 0), 32'hC0DE_000A, 32'hC0DE_000B, 5'd12));
    tbl.push_back(with_op(1, ins(1, 13, 1, 0, 0, 14, 1, 1, 1, 1), 32'hC0DE_000D, 32'd0, 5'd14));
    tbl.push_back(with_op(1, ins(1, 0, 0, 0, 0, 9, 1, 1, 1, 1), 32'd0, 32'd0, 5'd9));
    v = ins(1, 9, 1, 0, 0, 9, 1, 0, 1, 0);
    v.flush = 1'b1;
    tbl.push_back(v);
    tbl.push_back(with_op(1, ins(1, 9, 1, 0, 0, 9, 1, 0, 1, 1), 32'hC0DE_0009, 32'd0, 5'd9));

    for (int i = 0; i < 32; i++) rf_mem[i] = 32'hC0DE_0000 | 32'(i);
    rf_mem[0] = 32'hBAD0_0000;
    reg_rst_n = 1'b1;
    v = ins(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_rd = 0; id_rd_wr = 0; wb_en = 0; wb_addr = 0; wb_data = 0; flush = 0; ex_ready = 1;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i]);

    // Reset in the middle of operation: busy[5] set and EX holding a valid instruction.
    cyc(ins(1, 0, 0, 0, 0, 5, 1, 1, 1, 1));
    cyc(with_op(1, ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 32'd0, 32'd0, 5'd5));
    #2;
    do_reset();
    cyc(ins(1, 5, 1, 0, 0, 5, 1, 0, 1, 1));

    for (int i = 0; i < 600; i++) begin
      v = ins($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, 0, 0);
      if ($urandom_range(0, 9) < 4) v = with_wb(v, 5'($urandom_range(0, 7)), $urandom);
      v.flush = ($urandom_range(0, 9) == 0);
      cyc(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
